// File: rtl/snake_disp_pkg.sv
`default_nettype none
// ============================================================================
// Package     : snake_disp_pkg
// Description : Shared constants and types for the snake-game score readout.
//               Segment patterns are active-low {g,f,e,d,c,b,a}.
//               - SEG_BLANK / SEG_DASH / SEG_ZERO : fixed segment patterns
//               - conv_state_t                   : 2-bit converter FSM state
//               - pow10()                        : elaboration-time 10**n
// Revision    : 1.0 - initial release
// ============================================================================
package snake_disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_t;

    function automatic int unsigned pow10(input int unsigned n);
        int unsigned v_acc;
        v_acc = 1;
        for (int unsigned i = 0; i < n; i++) begin
            v_acc = v_acc * 10;
        end
        return v_acc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Sequential double-dabble (shift/add-3) binary-to-BCD engine.
//               One input bit per clock; result valid while o_done is high.
//               clk     : clock (rising edge)
//               resetn  : asynchronous active-low reset
//               i_start : start request, taken when o_ready is high
//               i_bin   : binary value, sampled on the accepting edge
//               o_ready : idle, can accept i_start
//               o_done  : one-cycle flag, o_bcd holds the final result
//               o_bcd   : BCD accumulator, DIGITS nibbles
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
    import snake_disp_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  i_start,
    input  logic [BIN_W-1:0]      i_bin,
    output logic                  o_ready,
    output logic                  o_done,
    output logic [4*DIGITS-1:0]   o_bcd
);

    localparam int c_BCD_W = 4 * DIGITS;
    localparam int c_CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    conv_state_t          r_state;
    conv_state_t          w_state_nxt;
    logic [BIN_W-1:0]     r_bin;
    logic [c_BCD_W-1:0]   r_bcd;
    logic [c_BCD_W-1:0]   w_bcd_adj;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 w_last;

    assign w_last = (r_cnt == c_CNT_W'(BIN_W - 1));

    // Add-3 correction on every nibble that would reach 10+ after doubling.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (i_start) w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (w_last)  w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_bin <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_bin <= i_bin;
                        r_bcd <= '0;
                        r_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    // Top-nibble carry is dropped: over-range inputs are
                    // flagged upstream and never displayed as digits.
                    r_bcd <= {w_bcd_adj[c_BCD_W-2:0], r_bin[BIN_W-1]};
                    r_bin <= {r_bin[BIN_W-2:0], 1'b0};
                    r_cnt <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_ready = (r_state == ST_IDLE);
    assign o_done  = (r_state == ST_DONE);
    assign o_bcd   = r_bcd;

endmodule
`default_nettype wire

// File: rtl/hex_decoder.sv
`default_nettype none
// ============================================================================
// Module      : hex_decoder
// Description : 4-bit value to active-low 7-segment pattern {g,f,e,d,c,b,a}.
//               i_digit : 4-bit value (0..F)
//               o_seg   : active-low segment pattern
// Revision    : 1.0 - initial release
// ============================================================================
module hex_decoder
    import snake_disp_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_digit)
            4'h0: o_seg = SEG_ZERO;
            4'h1: o_seg = 7'b1111001;
            4'h2: o_seg = 7'b0100100;
            4'h3: o_seg = 7'b0110000;
            4'h4: o_seg = 7'b0011001;
            4'h5: o_seg = 7'b0010010;
            4'h6: o_seg = 7'b0000010;
            4'h7: o_seg = 7'b1111000;
            4'h8: o_seg = 7'b0000000;
            4'h9: o_seg = 7'b0010000;
            4'hA: o_seg = 7'b0001000;
            4'hB: o_seg = 7'b0000011;
            4'hC: o_seg = 7'b1000110;
            4'hD: o_seg = 7'b0100001;
            4'hE: o_seg = 7'b0000110;
            4'hF: o_seg = 7'b0001110;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/score_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : score_display_ctrl
// Description : Snake-game score readout. Accepts a binary score over a
//               valid/ready handshake, converts it to BCD sequentially and
//               updates all digit registers and the overflow flag atomically.
//               Optional macro SCORE_DISPLAY_BLANK_EN : leading-zero blanking.
//               clk         : clock (rising edge)
//               resetn      : asynchronous active-low reset
//               score_valid : score holds a value to display
//               score       : unsigned binary score
//               score_ready : controller can accept a score
//               busy        : conversion in progress
//               ovf         : displayed value exceeded 10**NUM_DIGITS-1
//               hex_out     : active-low segments, digit i at [7i+6:7i]
// Revision    : 1.0 - initial release
// ============================================================================
module score_display_ctrl
    import snake_disp_pkg::*;
#(
    parameter int SCORE_W    = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    score_valid,
    input  logic [SCORE_W-1:0]      score,
    output logic                    score_ready,
    output logic                    busy,
    output logic                    ovf,
    output logic [7*NUM_DIGITS-1:0] hex_out
);

    localparam int unsigned c_MAX = pow10(NUM_DIGITS) - 1;

    logic                      w_ready;
    logic                      w_done;
    logic [4*NUM_DIGITS-1:0]   w_bcd;
    logic                      w_over;
    logic                      r_ovf_pend;
    logic                      r_ovf;
    logic [4*NUM_DIGITS-1:0]   r_digits;
    logic [NUM_DIGITS-1:0]     w_blank;

    // Range check on the binary input; the BCD result may have wrapped.
    assign w_over = (32'(score) > c_MAX);

    bin2bcd_seq #(
        .BIN_W  (SCORE_W),
        .DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clk     (clk),
        .resetn  (resetn),
        .i_start (score_valid),
        .i_bin   (score),
        .o_ready (w_ready),
        .o_done  (w_done),
        .o_bcd   (w_bcd)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ovf_pend <= 1'b0;
            r_ovf      <= 1'b0;
            r_digits   <= '0;
        end else begin
            if (score_valid && w_ready) begin
                r_ovf_pend <= w_over;
            end
            // Digits and flag move together so the display never tears.
            if (w_done) begin
                r_digits <= w_bcd;
                r_ovf    <= r_ovf_pend;
            end
        end
    end

`ifdef SCORE_DISPLAY_BLANK_EN
    // Walk from the top digit down; blank until the first nonzero digit.
    always_comb begin
        logic w_seen;
        w_seen  = 1'b0;
        w_blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (r_digits[4*i +: 4] != 4'd0) begin
                w_seen = 1'b1;
            end
            w_blank[i] = !w_seen;
        end
    end
`else
    assign w_blank = '0;
`endif

    generate
        for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
            logic [6:0] w_seg;

            hex_decoder u_dec (
                .i_digit (r_digits[4*g +: 4]),
                .o_seg   (w_seg)
            );

            // Dash outranks blanking.
            assign hex_out[7*g +: 7] = r_ovf      ? SEG_DASH  :
                                       w_blank[g] ? SEG_BLANK : w_seg;
        end
    endgenerate

    assign score_ready = w_ready;
    assign busy        = ~w_ready;
    assign ovf         = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_score_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_score_display_ctrl
// Description : Self-checking bench for score_display_ctrl (SCORE_W=14,
//               NUM_DIGITS=4). Directed and random scores against a decimal
//               arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_score_display_ctrl;

`ifdef SCORE_DISPLAY_BLANK_EN
    localparam bit c_BLANK_MODE = 1'b1;
`else
    localparam bit c_BLANK_MODE = 1'b0;
`endif

    localparam logic [6:0] c_DASH  = 7'b0111111;
    localparam logic [6:0] c_BLANK = 7'b1111111;

    logic        clk = 1'b0;
    logic        resetn;
    logic        score_valid;
    logic [13:0] score;
    logic        score_ready;
    logic        busy;
    logic        ovf;
    logic [27:0] hex_out;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [27:0] disp_exp;
    logic        ovf_exp;

    logic [6:0]  seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
                                  7'b0110000, 7'b0011001, 7'b0010010,
                                  7'b0000010, 7'b1111000, 7'b0000000,
                                  7'b0010000};

    score_display_ctrl #(
        .SCORE_W    (14),
        .NUM_DIGITS (4)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .score_valid (score_valid),
        .score       (score),
        .score_ready (score_ready),
        .busy        (busy),
        .ovf         (ovf),
        .hex_out     (hex_out)
    );

    always #5 clk = ~clk;

    // Decimal digits straight from the score value.
    function automatic logic [27:0] model(input int val, input bit o);
        logic [27:0] r;
        int          p;
        p = 1;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            if (o)
                r[7*i +: 7] = c_DASH;
            else if (c_BLANK_MODE && i > 0 && val < p)
                r[7*i +: 7] = c_BLANK;
            else
                r[7*i +: 7] = seg_tab[(val / p) % 10];
            p = p * 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Transfer one score and check the busy window and the exact update edge.
    // hold=1 keeps valid asserted with hold_val after the accepting edge.
    task automatic send(input int val, input bit hold, input int hold_val);
        int guard;
        bit ok;
        guard = 0;
        while (score_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_send", 32'(score_ready), 32'd1);
        score       = 14'(val);
        score_valid = 1'b1;
        @(posedge clk);
        #1;
        if (hold) begin
            score = 14'(hold_val);
        end else begin
            score_valid = 1'b0;
            score       = 14'($urandom);
        end
        ok = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (busy !== 1'b1 || score_ready !== 1'b0 ||
                hex_out !== disp_exp || ovf !== ovf_exp)
                ok = 1'b0;
        end
        check("busy_window_old_display", 32'(ok), 32'd1);
        ovf_exp  = (val > 9999);
        disp_exp = model(val, ovf_exp);
        @(negedge clk);
        check("hex_update", 32'(hex_out), 32'(disp_exp));
        check("ovf_update", 32'(ovf), 32'(ovf_exp));
        check("ready_after", 32'(score_ready), 32'd1);
        check("busy_after", 32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int v;
        resetn      = 1'b0;
        score_valid = 1'b0;
        score       = '0;
        disp_exp    = model(0, 1'b0);
        ovf_exp     = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_hex", 32'(hex_out), 32'(model(0, 1'b0)));
        check("reset_ready", 32'(score_ready), 32'd1);
        check("reset_ovf", 32'(ovf), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);

        // Basic conversion and boundaries
        send(1234, 1'b0, 0);
        send(9999, 1'b0, 0);
        send(10000, 1'b0, 0);
        send(5, 1'b0, 0);
        send(0, 1'b0, 0);
        send(16383, 1'b0, 0);
        send(7, 1'b0, 0);

        // Valid held during busy: second value taken once ready returns
        send(42, 1'b1, 77);
        send(77, 1'b0, 0);

        // Reset in the middle of a conversion
        @(negedge clk);
        score       = 14'd8888;
        score_valid = 1'b1;
        @(posedge clk);
        #1;
        score_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        disp_exp = model(0, 1'b0);
        ovf_exp  = 1'b0;
        check("abort_hex", 32'(hex_out), 32'(disp_exp));
        check("abort_ready", 32'(score_ready), 32'd1);
        check("abort_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        ok = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (hex_out !== disp_exp || score_ready !== 1'b1 || ovf !== 1'b0)
                ok = 1'b0;
        end
        check("abort_never_shows", 32'(ok), 32'd1);

        // Random scores, roughly a quarter of them over range
        for (int n = 0; n < 16; n++) begin
            if ($urandom_range(0, 3) == 0)
                v = int'($urandom_range(10000, 16383));
            else
                v = int'($urandom_range(0, 9999));
            send(v, 1'b0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
